// File: rtl/riscv_pkg.sv
// Shared ALU operation codes and result-select encodings for the execute pipeline.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_e;

  // Selects what the EX stage hands to MEM as its result.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_sel_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic/logic ops produce result; branch ops produce cmp_true with result 0.
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            cmp_true
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b[4:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result   = '0;
    cmp_true = 1'b0;
    case (alu_op_e'(alu_ctrl))
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {31'b0, lt_s};
      ALU_SLTU: result = {31'b0, lt_u};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_BEQ:  cmp_true = (a == b);
      ALU_BNE:  cmp_true = (a != b);
      ALU_BLT:  cmp_true = lt_s;
      ALU_BGE:  cmp_true = ~lt_s;
      ALU_BLTU: cmp_true = lt_u;
      ALU_BGEU: cmp_true = ~lt_u;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, control-flow redirect and the EX/MEM register.
// Define EX_FORWARD_EN to forward MEM/WB results into rs1/rs2 (matched on rs1_raddr_EX/rs2_raddr_EX).
module ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_EX,
  input  logic [XLEN-1:0] imm_EX,
  input  logic [XLEN-1:0] rs1_rdata_EX,
  input  logic [XLEN-1:0] rs2_rdata_EX,
  input  logic [4:0]      rs1_raddr_EX,
  input  logic [4:0]      rs2_raddr_EX,
  input  logic [4:0]      rd_waddr_EX,
  input  logic            ALU_src_EX,
  input  logic [3:0]      ALU_ctrl_EX,
  input  logic            branch_EX,
  input  logic            MemWrite_EX,
  input  logic            jal_EX,
  input  logic            jalr_EX,
  input  logic            rd_wen_EX,
  input  logic [1:0]      PMAItoReg_EX,
  input  logic            valid_EX,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      wb_rd,
  input  logic            wb_wen,
  output logic [XLEN-1:0] result_MEM,
  output logic [XLEN-1:0] store_data_MEM,
  output logic [4:0]      rd_waddr_MEM,
  output logic [1:0]      PMAItoReg_MEM,
  output logic            MemWrite_MEM,
  output logic            rd_wen_MEM,
  output logic            valid_MEM,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target
);

  logic [XLEN-1:0] result_reg;
  logic [XLEN-1:0] store_data_reg;
  logic [4:0]      rd_waddr_reg;
  logic [1:0]      pmai_reg;
  logic            mem_write_reg;
  logic            rd_wen_reg;
  logic            valid_reg;

  logic [XLEN-1:0] src_rdata [2];
  logic [4:0]      src_raddr [2];
  logic [XLEN-1:0] src_fwd   [2];
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign src_rdata[0] = rs1_rdata_EX;
  assign src_rdata[1] = rs2_rdata_EX;
  assign src_raddr[0] = rs1_raddr_EX;
  assign src_raddr[1] = rs2_raddr_EX;

`ifdef EX_FORWARD_EN
  logic mem_fwd_ok;
  logic wb_fwd_ok;

  // A load in MEM has no data yet, so it is never a forwarding source.
  assign mem_fwd_ok = valid_reg & rd_wen_reg & (rd_waddr_reg != 5'd0) &
                      (pmai_reg != RES_MEM);
  assign wb_fwd_ok  = wb_wen & (wb_rd != 5'd0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        src_fwd[gi] = src_rdata[gi];
        if (mem_fwd_ok && (rd_waddr_reg == src_raddr[gi]))
          src_fwd[gi] = result_reg;
        else if (wb_fwd_ok && (wb_rd == src_raddr[gi]))
          src_fwd[gi] = wb_data;
      end
    end
  endgenerate
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{wb_data, wb_rd, wb_wen, src_raddr[0], src_raddr[1]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign src_fwd[gi] = src_rdata[gi];
    end
  endgenerate
`endif

  assign rs1_fwd = src_fwd[0];
  assign rs2_fwd = src_fwd[1];

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic            cmp_true;
  logic [XLEN-1:0] ex_result;

  assign op_b = ALU_src_EX ? imm_EX : rs2_fwd;

  alu u_alu (
    .a        (rs1_fwd),
    .b        (op_b),
    .alu_ctrl (ALU_ctrl_EX),
    .result   (alu_result),
    .cmp_true (cmp_true)
  );

  always_comb begin
    ex_result = alu_result;
    case (res_sel_e'(PMAItoReg_EX))
      RES_PC4: ex_result = PC_EX + 32'd4;
      RES_IMM: ex_result = imm_EX;
      default: ex_result = alu_result;
    endcase
  end

  assign pc_redirect = valid_EX & ~stall & (jal_EX | jalr_EX | (branch_EX & cmp_true));
  assign pc_target   = jalr_EX ? ((rs1_fwd + imm_EX) & ~32'd1) : (PC_EX + imm_EX);

  // Flush only kills the qualifiers; the data fields are left as they were.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg     <= '0;
      store_data_reg <= '0;
      rd_waddr_reg   <= '0;
      pmai_reg       <= '0;
      mem_write_reg  <= 1'b0;
      rd_wen_reg     <= 1'b0;
      valid_reg      <= 1'b0;
    end else if (flush) begin
      mem_write_reg  <= 1'b0;
      rd_wen_reg     <= 1'b0;
      valid_reg      <= 1'b0;
    end else if (!stall) begin
      result_reg     <= ex_result;
      store_data_reg <= rs2_fwd;
      rd_waddr_reg   <= rd_waddr_EX;
      pmai_reg       <= PMAItoReg_EX;
      mem_write_reg  <= MemWrite_EX & valid_EX;
      rd_wen_reg     <= rd_wen_EX & valid_EX;
      valid_reg      <= valid_EX;
    end
  end

  assign result_MEM     = result_reg;
  assign store_data_MEM = store_data_reg;
  assign rd_waddr_MEM   = rd_waddr_reg;
  assign PMAItoReg_MEM  = pmai_reg;
  assign MemWrite_MEM   = mem_write_reg;
  assign rd_wen_MEM     = rd_wen_reg;
  assign valid_MEM      = valid_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a behavioural model, plus directed corner cases.
module tb_ex_stage;

  typedef struct {
    logic [31:0] pc, imm, rs1, rs2, wb_data;
    logic [4:0]  rs1_a, rs2_a, rd, wb_rd;
    logic [3:0]  ctrl;
    logic [1:0]  pm;
    logic        src, br, mw, jal, jalr, wen, valid, stall, flush, rst, wb_wen;
  } stim_t;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_EX, imm_EX, rs1_rdata_EX, rs2_rdata_EX, wb_data;
  logic [4:0]  rs1_raddr_EX, rs2_raddr_EX, rd_waddr_EX, wb_rd;
  logic        ALU_src_EX, branch_EX, MemWrite_EX, jal_EX, jalr_EX, rd_wen_EX, valid_EX;
  logic [3:0]  ALU_ctrl_EX;
  logic [1:0]  PMAItoReg_EX;
  logic        stall, flush, wb_wen;
  logic [31:0] result_MEM, store_data_MEM, pc_target;
  logic [4:0]  rd_waddr_MEM;
  logic [1:0]  PMAItoReg_MEM;
  logic        MemWrite_MEM, rd_wen_MEM, valid_MEM, pc_redirect;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .PC_EX(PC_EX), .imm_EX(imm_EX),
    .rs1_rdata_EX(rs1_rdata_EX), .rs2_rdata_EX(rs2_rdata_EX),
    .rs1_raddr_EX(rs1_raddr_EX), .rs2_raddr_EX(rs2_raddr_EX),
    .rd_waddr_EX(rd_waddr_EX), .ALU_src_EX(ALU_src_EX), .ALU_ctrl_EX(ALU_ctrl_EX),
    .branch_EX(branch_EX), .MemWrite_EX(MemWrite_EX), .jal_EX(jal_EX), .jalr_EX(jalr_EX),
    .rd_wen_EX(rd_wen_EX), .PMAItoReg_EX(PMAItoReg_EX), .valid_EX(valid_EX),
    .stall(stall), .flush(flush), .wb_data(wb_data), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .result_MEM(result_MEM), .store_data_MEM(store_data_MEM), .rd_waddr_MEM(rd_waddr_MEM),
    .PMAItoReg_MEM(PMAItoReg_MEM), .MemWrite_MEM(MemWrite_MEM), .rd_wen_MEM(rd_wen_MEM),
    .valid_MEM(valid_MEM), .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model of the EX/MEM register; m_known drops after a flush (data fields don't-care).
  logic [31:0] m_result, m_store;
  logic [4:0]  m_rd;
  logic [1:0]  m_pm;
  logic        m_mw, m_wen, m_valid, m_known;
  logic        obs_redirect;
  logic [31:0] obs_target;

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c);
    int signed sa, sb;
    sa = a; sb = b;
    r = 0; c = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a << b[4:0];
      3: r = (sa < sb) ? 1 : 0;
      4: r = (a < b) ? 1 : 0;
      5: r = a ^ b;
      6: r = a >> b[4:0];
      7: r = sa >>> b[4:0];
      8: r = a | b;
      9: r = a & b;
      10: c = (a == b);
      11: c = (a != b);
      12: c = (sa < sb);
      13: c = (sa >= sb);
      14: c = (a < b);
      default: c = (a >= b);
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] ra, input logic [31:0] rdata,
                                          input stim_t s);
    if (!FWD) return rdata;
    if (m_valid && m_wen && m_rd != 0 && m_pm != 2'b01 && m_rd == ra) return m_result;
    if (s.wb_wen && s.wb_rd != 0 && s.wb_rd == ra) return s.wb_data;
    return rdata;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s.pc = 0; s.imm = 0; s.rs1 = 0; s.rs2 = 0; s.wb_data = 0;
    s.rs1_a = 0; s.rs2_a = 0; s.rd = 0; s.wb_rd = 0; s.ctrl = 0; s.pm = 0;
    s.src = 0; s.br = 0; s.mw = 0; s.jal = 0; s.jalr = 0; s.wen = 0; s.valid = 0;
    s.stall = 0; s.flush = 0; s.rst = 0; s.wb_wen = 0;
    return s;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_regs();
    check("valid_MEM", {31'b0, valid_MEM}, {31'b0, m_valid});
    check("MemWrite_MEM", {31'b0, MemWrite_MEM}, {31'b0, m_mw});
    check("rd_wen_MEM", {31'b0, rd_wen_MEM}, {31'b0, m_wen});
    if (m_known) begin
      check("result_MEM", result_MEM, m_result);
      check("store_data_MEM", store_data_MEM, m_store);
      check("rd_waddr_MEM", {27'b0, rd_waddr_MEM}, {27'b0, m_rd});
      check("PMAItoReg_MEM", {30'b0, PMAItoReg_MEM}, {30'b0, m_pm});
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with registers checked.
  task automatic step(input stim_t s);
    logic [31:0] a, b2, bop, alu_r, res, tgt;
    logic        cmp, redir;
    PC_EX = s.pc; imm_EX = s.imm; rs1_rdata_EX = s.rs1; rs2_rdata_EX = s.rs2;
    rs1_raddr_EX = s.rs1_a; rs2_raddr_EX = s.rs2_a; rd_waddr_EX = s.rd;
    ALU_src_EX = s.src; ALU_ctrl_EX = s.ctrl; branch_EX = s.br; MemWrite_EX = s.mw;
    jal_EX = s.jal; jalr_EX = s.jalr; rd_wen_EX = s.wen; PMAItoReg_EX = s.pm;
    valid_EX = s.valid; stall = s.stall; flush = s.flush; rst = s.rst;
    wb_data = s.wb_data; wb_rd = s.wb_rd; wb_wen = s.wb_wen;
    #1;
    a   = ref_fwd(s.rs1_a, s.rs1, s);
    b2  = ref_fwd(s.rs2_a, s.rs2, s);
    bop = s.src ? s.imm : b2;
    ref_alu(s.ctrl, a, bop, alu_r, cmp);
    res = (s.pm == 2'b10) ? s.pc + 4 : (s.pm == 2'b11) ? s.imm : alu_r;
    redir = s.valid && !s.stall && (s.jal || s.jalr || (s.br && cmp));
    tgt = s.jalr ? ((a + s.imm) & 32'hFFFF_FFFE) : s.pc + s.imm;
    obs_redirect = pc_redirect;
    obs_target = pc_target;
    check("pc_redirect", {31'b0, pc_redirect}, {31'b0, redir});
    check("pc_target", pc_target, tgt);
    @(posedge clk);
    if (s.rst) begin
      m_result = 0; m_store = 0; m_rd = 0; m_pm = 0;
      m_mw = 0; m_wen = 0; m_valid = 0; m_known = 1;
    end else if (s.flush) begin
      m_mw = 0; m_wen = 0; m_valid = 0; m_known = 0;
    end else if (!s.stall) begin
      m_result = res; m_store = b2; m_rd = s.rd; m_pm = s.pm;
      m_mw = s.mw && s.valid; m_wen = s.wen && s.valid; m_valid = s.valid; m_known = 1;
    end
    @(negedge clk);
    check_regs();
  endtask

  initial begin
    stim_t s;
    logic [31:0] held;
    s = nop();
    s.rst = 1;
    rst = 1; stall = 1; flush = 1; valid_EX = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(s);
    check("rst_result", result_MEM, 32'h0);
    check("rst_valid", {31'b0, valid_MEM}, 32'h0);

    // Signed overflow on ADD
    s = nop(); s.valid = 1; s.wen = 1; s.rd = 3; s.rs1 = 32'h7FFF_FFFF; s.rs2 = 1;
    step(s);
    check("add_ovf_result", result_MEM, 32'h8000_0000);
    check("add_ovf_wen", {31'b0, rd_wen_MEM}, 32'h1);

    // Signed vs unsigned branch compare
    s = nop(); s.valid = 1; s.br = 1; s.ctrl = 12; s.rs1 = 32'hFFFF_FFFF; s.rs2 = 1;
    s.pc = 32'h100; s.imm = 32'h20;
    step(s);
    check("blt_redirect", {31'b0, obs_redirect}, 32'h1);
    check("blt_target", obs_target, 32'h120);
    s.ctrl = 14;
    step(s);
    check("bltu_redirect", {31'b0, obs_redirect}, 32'h0);

    // JALR clears bit 0 and links PC+4
    s = nop(); s.valid = 1; s.jalr = 1; s.wen = 1; s.rd = 1; s.rs1 = 32'h1003;
    s.pm = 2'b10; s.pc = 32'h40;
    step(s);
    check("jalr_target", obs_target, 32'h1002);
    check("jalr_link", result_MEM, 32'h44);

    // flush wins over stall
    s = nop(); s.valid = 1; s.wen = 1; s.rd = 2; s.rs1 = 1; s.rs2 = 1; s.stall = 1; s.flush = 1;
    step(s);
    check("flush_valid", {31'b0, valid_MEM}, 32'h0);
    check("flush_wen", {31'b0, rd_wen_MEM}, 32'h0);

    // Stall holds everything for several cycles
    s = nop(); s.valid = 1; s.wen = 1; s.rd = 4; s.rs1 = 5; s.rs2 = 6;
    step(s);
    held = result_MEM;
    for (int i = 0; i < 3; i++) begin
      s = nop(); s.valid = 1; s.wen = 1; s.rd = 9; s.rs1 = $urandom; s.rs2 = $urandom;
      s.stall = 1; s.jal = 1;
      step(s);
      check("stall_result", result_MEM, 32'd11);
      check("stall_rd", {27'b0, rd_waddr_MEM}, 32'd4);
      check("stall_redirect", {31'b0, obs_redirect}, 32'h0);
    end

    // Reset in the middle of a valid instruction
    s = nop(); s.valid = 1; s.wen = 1; s.mw = 1; s.rd = 7; s.rs1 = 3; s.rs2 = 4; s.rst = 1;
    step(s);
    check("midrst_result", result_MEM, 32'h0);
    check("midrst_valid", {31'b0, valid_MEM}, 32'h0);
    check("midrst_rd", {27'b0, rd_waddr_MEM}, 32'h0);
    s = nop(); s.jal = 1;
    step(s);
    check("idle_redirect", {31'b0, obs_redirect}, 32'h0);

`ifdef EX_FORWARD_EN
    // MEM result beats WB for the same register; x0 is never forwarded
    s = nop(); s.valid = 1; s.wen = 1; s.rd = 5; s.rs1 = 1; s.rs2 = 2;
    step(s);
    s = nop(); s.valid = 1; s.wen = 1; s.rd = 6; s.rs1_a = 5; s.rs2_a = 5;
    s.wb_rd = 5; s.wb_data = 9; s.wb_wen = 1;
    step(s);
    check("fwd_mem_priority", result_MEM, 32'd6);
    s = nop(); s.valid = 1; s.wen = 1; s.rd = 0; s.rs1 = 3; s.rs2 = 4;
    step(s);
    s = nop(); s.valid = 1; s.wen = 1; s.rd = 8; s.rs1 = 1; s.rs2 = 1;
    step(s);
    check("fwd_x0_none", result_MEM, 32'd2);
`endif

    for (int n = 0; n < 400; n++) begin
      s = nop();
      s.pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      s.imm = rand_val(); s.rs1 = rand_val(); s.rs2 = rand_val(); s.wb_data = rand_val();
      s.rs1_a = 5'($urandom_range(0, 7)); s.rs2_a = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 7)); s.wb_rd = 5'($urandom_range(0, 7));
      s.ctrl = 4'($urandom_range(0, 15)); s.pm = 2'($urandom_range(0, 3));
      s.src = 1'($urandom_range(0, 1)); s.br = 1'($urandom_range(0, 1));
      s.mw = 1'($urandom_range(0, 1)); s.wen = 1'($urandom_range(0, 1));
      s.wb_wen = 1'($urandom_range(0, 1));
      s.jal = ($urandom_range(0, 7) == 0); s.jalr = ($urandom_range(0, 7) == 0);
      s.valid = ($urandom_range(0, 4) != 0);
      s.stall = ($urandom_range(0, 4) == 0); s.flush = ($urandom_range(0, 7) == 0);
      s.rst = ($urandom_range(0, 49) == 0);
      step(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have inputs PC_EX, imm_EX, rs1_rdata_EX, rs2_rdata_EX  input  32 each  operands from the ID/EX register.
REQ-004 SHALL have inputs rd_waddr_EX (5), ALU_src_EX (1), ALU_ctrl_EX (4), branch_EX, MemWrite_EX, jal_EX, jalr_EX, rd_wen_EX (1 each), PMAItoReg_EX (2), valid_EX (1)  input  decoded controls.
REQ-005 SHALL have inputs stall  input  1  hold EX/MEM; flush  input  1  insert bubble into EX/MEM.
REQ-006 SHALL have inputs wb_data (32), wb_rd (5), wb_wen (1)  input  WB write-back, used for forwarding.
REQ-007 SHALL have outputs result_MEM (32), store_data_MEM (32), rd_waddr_MEM (5), PMAItoReg_MEM (2), MemWrite_MEM, rd_wen_MEM, valid_MEM (1 each)  output  EX/MEM register.
REQ-008 SHALL have outputs pc_redirect (1), pc_target (32)  output  combinational control-flow redirect.

Function
REQ-009 ALU_ctrl codes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
REQ-010 Operand B SHALL be imm_EX when ALU_src_EX=1, otherwise forwarded rs2.
REQ-011 Shifts SHALL use B[4:0] only; ADD/SUB SHALL wrap modulo 2^32; SLT/SLTU SHALL yield 0 or 1.
REQ-012 Codes 10-15 SHALL produce cmp_true (signed for BLT/BGE, unsigned for BLTU/BGEU) and ALU result 0.
REQ-013 ex_result SHALL be ALU result for PMAItoReg 00 or 01, PC_EX+4 for 10, imm_EX for 11.
REQ-014 pc_redirect SHALL be valid_EX & ~stall & (jal_EX | jalr_EX | (branch_EX & cmp_true)).
REQ-015 pc_target SHALL be (rs1_fwd+imm_EX) with bit0 cleared when jalr_EX=1, otherwise PC_EX+imm_EX.
REQ-016 On each clock with flush=1: valid_MEM, MemWrite_MEM and rd_wen_MEM SHALL become 0; other fields don't-care.
REQ-017 On a clock with flush=0, stall=1: all EX/MEM outputs SHALL hold.
REQ-018 Otherwise EX/MEM SHALL capture ex_result, forwarded rs2, rd, PMAItoReg, and MemWrite/rd_wen ANDed with valid_EX, plus valid_EX; latency 1 cycle.
REQ-019 flush SHALL take priority over stall when both are asserted.

Reset
REQ-020 With rst=1 at a clock edge, all EX/MEM outputs SHALL become 0; rst SHALL override flush and stall.
REQ-021 pc_redirect SHALL be 0 while valid_EX=0, including the cycles after reset.

Configuration
REQ-022 Macro EX_FORWARD_EN defined: rs1/rs2 SHALL be replaced by forwarded values; MEM source (result_MEM, when valid_MEM & rd_wen_MEM & rd_waddr_MEM!=0 & PMAItoReg_MEM!=01 & match) has priority over WB source (wb_data, when wb_wen & wb_rd!=0 & match).
REQ-023 Macro EX_FORWARD_EN undefined: rs1_rdata_EX/rs2_rdata_EX SHALL be used unmodified; wb_* ports SHALL remain present and be ignored.

Structure
REQ-024 ALU_ctrl codes and PMAItoReg encodings SHALL be defined in shared package riscv_pkg.
REQ-025 The combinational ALU SHALL be a sub-module alu (operands, ALU_ctrl in; result, cmp_true out); forwarding, redirect and EX/MEM register SHALL stay in ex_stage.

Verification
REQ-026 ADD rs1=0x7FFFFFFF, rs2=1, valid -> result_MEM=0x80000000 one cycle later, rd_wen_MEM=1.
REQ-027 BLT rs1=0xFFFFFFFF, rs2=1, branch=1, PC=0x100, imm=0x20 -> pc_redirect=1, pc_target=0x120; BLTU same operands -> pc_redirect=0.
REQ-028 JALR rs1=0x1003, imm=0, PMAItoReg=10, PC=0x40 -> pc_target=0x1002, result_MEM=0x44.
REQ-029 stall=1 and flush=1 together with a valid ADD -> valid_MEM=0, rd_wen_MEM=0; stall alone -> outputs unchanged for the full stall duration.
REQ-030 EX_FORWARD_EN: back-to-back ADD x5=3 then ADD x6=x5+x5 with wb_rd=5, wb_data=9 -> second result 6 (MEM priority); rd=x0 producer -> no forwarding.
REQ-031 rst asserted mid-stream with valid_EX=1 -> all outputs 0 at next edge, valid_MEM=0.
